// File: rtl/om_pkg.sv
// Object memory map shared by the arbiter, game logic and renderer:
// 100 play cells followed by level metadata, cell type in bits [10:8].
package om_pkg;

  localparam int OM_AW        = 7;
  localparam int OM_DW        = 11;
  localparam int OM_DEPTH     = 103;
  localparam int OM_META_BASE = 100;
  localparam int OM_TYPE_LSB  = 8;

  typedef enum logic [2:0] {
    CELL_EMPTY          = 3'd0,
    CELL_TARGET         = 3'd1,
    CELL_WALL           = 3'd2,
    CELL_PLAYER         = 3'd3,
    CELL_BOX            = 3'd5,
    CELL_BOX_ON_TARGET  = 3'd6
  } om_cell_e;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  function automatic om_cell_e om_cell_type(input logic [OM_DW-1:0] word);
    return om_cell_e'(word[OM_TYPE_LSB +: 3]);
  endfunction

  function automatic logic om_is_meta(input logic [OM_AW-1:0] a);
    return (a >= OM_AW'(OM_META_BASE)) && (a < OM_AW'(OM_DEPTH));
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: first set request at or after ptr, wrapping,
// returned as a one-hot vector (all zero when nothing is requested).
module rr_pick
  import om_pkg::*;
#(
  parameter int NREQ = 3,
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);

  logic found;
  int   idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/om_port_arbiter.sv
// Round-robin arbiter in front of the single-port object memory with burst
// locking, starvation bound, tagged read return and address range protection.
module om_port_arbiter
  import om_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int AW        = OM_AW,
  parameter int DW        = OM_DW,
  parameter int DEPTH     = OM_DEPTH,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   lock,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  input  logic [NREQ-1:0]   we,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rvalid,
  output logic [DW-1:0]     rdata,
  output logic              err,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic              mem_wren,
  input  logic [DW-1:0]     mem_rdata
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_e      state_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] rvalid_q;
  logic [PW-1:0]   ptr_q;
  logic [BW-1:0]   burst_q;
  logic            rd_oor_q;
  logic            err_q;

  logic [AW-1:0]   own_addr;
  logic [DW-1:0]   own_wdata;
  logic            own_we;
  logic            own_req;
  logic            own_lock;

  logic [NREQ-1:0] others;
  logic            others_pend;
  logic [NREQ-1:0] pick_oh;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   ptr_d;
  logic [BW-1:0]   burst_d;
  logic            burst_max;
  logic            take_grant;
  logic            in_range;
  logic            rd_issue;

  // Owner's request fields; all zero when nobody holds the grant.
  always_comb begin
    own_addr  = '0;
    own_wdata = '0;
    own_we    = 1'b0;
    own_req   = 1'b0;
    own_lock  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        own_addr  = addr[i*AW +: AW];
        own_wdata = wdata[i*DW +: DW];
        own_we    = we[i];
        own_req   = req[i];
        own_lock  = lock[i];
      end
    end
  end

  // In IDLE gnt_q is zero, so "others" is simply every pending request.
  assign others      = req & ~gnt_q;
  assign others_pend = |others;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req (others),
    .ptr (ptr_q),
    .gnt (pick_oh)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) begin
        pick_idx = PW'(i);
      end
    end
  end

  assign ptr_d     = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
  assign burst_d   = burst_q + 1'b1;
  assign burst_max = (burst_q >= BW'(MAX_BURST - 1));

  // A new owner is taken whenever someone else waits and the current owner
  // has dropped out, does not lock, or is on its last allowed locked access.
  assign take_grant = others_pend &
                      ((state_q == ARB_IDLE) | ~own_req | ~own_lock | burst_max);

  assign in_range  = ({1'b0, own_addr} < (AW+1)'(DEPTH));
  assign rd_issue  = own_req & ~own_we;

  assign mem_addr  = own_addr;
  assign mem_wdata = own_wdata;
  assign mem_wren  = ~reset & own_req & own_we & in_range;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      gnt_q    <= '0;
      ptr_q    <= '0;
      burst_q  <= '0;
      rvalid_q <= '0;
      rd_oor_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= rd_issue ? gnt_q : '0;
      rd_oor_q <= rd_issue & ~in_range;
      err_q    <= own_req & ~in_range;
      if (take_grant) begin
        state_q <= ARB_OWNED;
        gnt_q   <= pick_oh;
        ptr_q   <= ptr_d;
        burst_q <= '0;
      end else begin
        unique case (state_q)
          ARB_IDLE: begin
            gnt_q <= '0;
          end
          ARB_OWNED: begin
            if (!own_req) begin
              state_q <= ARB_IDLE;
              gnt_q   <= '0;
              burst_q <= '0;
            end else if (others_pend) begin
              burst_q <= burst_d;
            end
          end
        endcase
      end
    end
  end

  assign gnt    = gnt_q;
  assign rvalid = rvalid_q;
  assign err    = err_q;
  // Out-of-range reads still complete, but never expose memory contents.
  assign rdata  = (|rvalid_q && !rd_oor_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_om_port_arbiter.sv
// Bench for om_port_arbiter: directed table, hand sequences and random
// traffic, all checked against a cycle-level behavioural model.
module tb_om_port_arbiter;

  localparam int N    = 3;
  localparam int AW   = 7;
  localparam int DW   = 11;
  localparam int DEP  = 103;
  localparam int MAXB = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req, lock, we;
  logic [N*AW-1:0]   addr;
  logic [N*DW-1:0]   wdata;
  logic [N-1:0]      gnt, rvalid;
  logic [DW-1:0]     rdata;
  logic              err;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_wren;
  logic [DW-1:0]     mem_rdata;

  om_port_arbiter #(
    .NREQ(N), .AW(AW), .DW(DW), .DEPTH(DEP), .MAX_BURST(MAXB)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .addr(addr),
    .wdata(wdata), .we(we), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wren(mem_wren), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Object memory: single port, registered read.
  logic [DW-1:0] tbmem [0:127];
  always @(posedge clk) begin
    if (mem_wren) tbmem[mem_addr] <= mem_wdata;
    mem_rdata <= tbmem[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int            m_owner = -1;
  int            m_ptr   = 0;
  int            m_burst = 0;
  int            m_rv    = -1;
  logic [DW-1:0] m_rdval = '0;
  logic          m_err   = 1'b0;
  logic [DW-1:0] shadow [0:127];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] m, input int start);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (m[j]) return j;
    end
    return -1;
  endfunction

  task automatic grant_to(input int n);
    m_owner = n;
    m_ptr   = (n + 1) % N;
    m_burst = 0;
  endtask

  task automatic model_step();
    int            o;
    logic          acc;
    logic [AW-1:0] a;
    logic [N-1:0]  oth;
    if (reset) begin
      m_owner = -1; m_ptr = 0; m_burst = 0; m_rv = -1; m_err = 1'b0; m_rdval = '0;
      return;
    end
    o = m_owner; acc = 1'b0; a = '0;
    if (o >= 0) begin
      acc = req[o];
      a   = addr[o*AW +: AW];
    end
    m_rv = -1; m_err = 1'b0; m_rdval = '0;
    if (acc) begin
      m_err = (int'(a) >= DEP);
      if (!we[o]) begin
        m_rv    = o;
        m_rdval = (int'(a) < DEP) ? shadow[a] : '0;
      end else if (int'(a) < DEP) begin
        shadow[a] = wdata[o*DW +: DW];
      end
    end
    if (o < 0) begin
      if (req != 0) grant_to(pick(req, m_ptr));
    end else begin
      oth = req & ~(N'(1) << o);
      if (!req[o]) begin
        if (oth != 0) grant_to(pick(oth, (o + 1) % N));
        else m_owner = -1;
      end else if (oth != 0) begin
        if (!lock[o] || (m_burst + 1 >= MAXB)) grant_to(pick(oth, (o + 1) % N));
        else m_burst++;
      end
    end
  endtask

  // Called at posedge+1: check this cycle's outputs, advance model, move on.
  task automatic tick();
    int            o;
    logic          acc;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [N-1:0]  eg, erv;
    #2;
    o = m_owner; acc = 1'b0; a = '0; wd = '0; eg = '0; erv = '0;
    if (o >= 0) begin
      acc = req[o];
      a   = addr[o*AW +: AW];
      wd  = wdata[o*DW +: DW];
      eg  = N'(1) << o;
    end
    if (m_rv >= 0) erv = N'(1) << m_rv;
    chk("gnt",       32'(gnt),       32'(eg));
    chk("mem_addr",  32'(mem_addr),  32'(a));
    chk("mem_wdata", 32'(mem_wdata), 32'(wd));
    chk("mem_wren",  32'(mem_wren),  32'(!reset && acc && we[o] && int'(a) < DEP));
    chk("rvalid",    32'(rvalid),    32'(erv));
    chk("rdata",     32'(rdata),     32'(m_rdval));
    chk("err",       32'(err),       32'(m_err));
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0; lock = '0; we = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0]  req, lock, we;
    logic [AW-1:0] a0, a1, a2;
    logic [N-1:0]  egnt;
    logic          ewren;
    logic [N-1:0]  erv;
    logic          eerr;
  } vec_t;

  vec_t tv [10];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int            n1, held, wr;
    logic [DW-1:0] exp_rd;

    tv[0] = '{3'b111, 3'b000, 3'b000, 7'd10,  7'd20, 7'd30,  3'b000, 1'b0, 3'b000, 1'b0};
    tv[1] = '{3'b111, 3'b000, 3'b000, 7'd10,  7'd20, 7'd30,  3'b001, 1'b0, 3'b000, 1'b0};
    tv[2] = '{3'b111, 3'b000, 3'b000, 7'd10,  7'd20, 7'd30,  3'b010, 1'b0, 3'b001, 1'b0};
    tv[3] = '{3'b111, 3'b000, 3'b000, 7'd10,  7'd20, 7'd30,  3'b100, 1'b0, 3'b010, 1'b0};
    tv[4] = '{3'b111, 3'b000, 3'b000, 7'd10,  7'd20, 7'd30,  3'b001, 1'b0, 3'b100, 1'b0};
    tv[5] = '{3'b111, 3'b000, 3'b111, 7'd10,  7'd20, 7'd110, 3'b010, 1'b1, 3'b001, 1'b0};
    tv[6] = '{3'b111, 3'b000, 3'b111, 7'd10,  7'd20, 7'd110, 3'b100, 1'b0, 3'b000, 1'b0};
    tv[7] = '{3'b001, 3'b000, 3'b000, 7'd127, 7'd20, 7'd30,  3'b001, 1'b0, 3'b000, 1'b1};
    tv[8] = '{3'b000, 3'b000, 3'b000, 7'd127, 7'd20, 7'd30,  3'b001, 1'b0, 3'b001, 1'b1};
    tv[9] = '{3'b000, 3'b000, 3'b000, 7'd127, 7'd20, 7'd30,  3'b000, 1'b0, 3'b000, 1'b0};

    for (int i = 0; i < 128; i++) shadow[i] = '0;
    reset = 1'b1; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Preload every valid cell through requester 0.
    req = 3'b001; lock = 3'b001; we = 3'b001;
    tick();
    for (int a = 0; a < DEP; a++) begin
      addr[0 +: AW]  = AW'(a);
      wdata[0 +: DW] = DW'($urandom());
      tick();
    end
    req = '0; lock = '0; we = '0;
    tick();
    $display("preload done, %0d words", DEP);

    // Reset then single read of metadata word 100.
    do_reset();
    req = 3'b001; we = 3'b000; addr = '0; addr[0 +: AW] = 7'd100;
    tick();
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_addr", 32'(mem_addr), 32'd100);
    exp_rd = shadow[100];
    tick();
    chk("t1_rvalid", 32'(rvalid), 32'h1);
    chk("t1_rdata", 32'(rdata), 32'(exp_rd));
    chk("t1_err", 32'(err), 32'h0);
    $display("read addr 100 -> rvalid=%b rdata=%0h", rvalid, rdata);
    req = '0;
    tick();
    tick();

    // Table: round robin, out-of-range write and read.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      req = tv[i].req; lock = tv[i].lock; we = tv[i].we;
      addr = {tv[i].a2, tv[i].a1, tv[i].a0};
      wdata = N*DW'({$urandom(), $urandom()});
      #2;
      chk("tv_gnt",    32'(gnt),      32'(tv[i].egnt));
      chk("tv_wren",   32'(mem_wren), 32'(tv[i].ewren));
      chk("tv_rvalid", 32'(rvalid),   32'(tv[i].erv));
      chk("tv_err",    32'(err),      32'(tv[i].eerr));
      $display("vec %0d req=%b we=%b gnt=%b wren=%b rvalid=%b err=%b",
               i, req, we, gnt, mem_wren, rvalid, err);
      tick();
    end

    // Starvation bound: requester 1 locked while requester 0 waits.
    do_reset();
    req = 3'b010; lock = 3'b010; we = '0; addr = '0; addr[AW +: AW] = 7'd5;
    tick();
    req = 3'b011;
    n1 = 0;
    for (int c = 0; c < 40 && gnt != 3'b001; c++) begin
      if (gnt == 3'b010) n1++;
      tick();
    end
    chk("burst_count", 32'(n1), 32'(MAXB));
    chk("burst_switch_gnt", 32'(gnt), 32'h1);
    $display("burst: requester 1 made %0d accesses before switch", n1);
    req = '0; lock = '0;
    tick();

    // Lone locked writer: 99 writes with no forced switch.
    do_reset();
    req = 3'b100; lock = 3'b100; we = 3'b100; addr = '0;
    tick();
    held = 0; wr = 0;
    for (int a = 0; a < 99; a++) begin
      addr[2*AW +: AW]  = AW'(a);
      wdata[2*DW +: DW] = DW'($urandom());
      #2;
      if (gnt == 3'b100) held++;
      if (mem_wren) wr++;
      #0;
      tick();
    end
    chk("w99_held", 32'(held), 32'd99);
    chk("w99_wren", 32'(wr), 32'd99);
    $display("lone writer: held=%0d writes=%0d", held, wr);
    req = '0; lock = '0; we = '0;
    tick();

    // Reset during an in-flight read.
    do_reset();
    req = 3'b001; we = '0; addr = '0; addr[0 +: AW] = 7'd50;
    tick();
    reset = 1'b1;
    tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    reset = 1'b0;
    req = 3'b110;
    tick();
    chk("rst_first_gnt", 32'(gnt), 32'h2);
    $display("after reset release gnt=%b", gnt);
    req = '0;
    tick();

    // Random traffic; second half keeps everyone locked to hit the bound.
    for (int c = 0; c < 600; c++) begin
      req  = N'($urandom());
      lock = (c >= 300) ? 3'b111 : N'($urandom());
      we   = N'($urandom());
      for (int r = 0; r < N; r++) begin
        addr[r*AW +: AW]  = ($urandom_range(0, 9) < 8) ? AW'($urandom_range(0, DEP - 1))
                                                       : AW'($urandom_range(0, 127));
        wdata[r*DW +: DW] = DW'($urandom());
      end
      if (c >= 300 && $urandom_range(0, 3) != 0) req = 3'b111;
      reset = ($urandom_range(0, 80) == 0);
      tick();
    end
    reset = 1'b0;
    $display("random phase done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
